// File: rtl/config_loader.sv
// ----------------------------------------------------------------------------
// config_loader
//
// Serializes host configuration words into the switchbox CRAM chain, MSB of
// each word first, one bit per clock qualified by config_en. While shifting,
// the bits leaving the chain are collected into readback words. A one-cycle
// done pulse marks the end of a CHAIN_LEN-bit frame.
//
// Parameters
//   CHAIN_LEN       total CRAM bits in the downstream chain (>= 1)
//   WORD_W          host word width (>= 1); CHAIN_LEN need not be a multiple
//
// Ports
//   clk             system clock, rising edge
//   nrst            asynchronous active-low reset
//   start           begin a frame (honoured only while idle)
//   word_valid      host word available
//   word_data       host word, bit WORD_W-1 shifted first
//   word_ready      loader accepts word_data this cycle
//   config_en       chain shift enable (registered)
//   config_data_in  chain serial input (registered)
//   config_data_out chain serial output
//   rd_valid        one-cycle pulse when rd_word updates
//   rd_word         readback word, first captured bit in bit WORD_W-1
//   busy            loader is not idle
//   done            one-cycle pulse in the cycle after the frame's last bit
// ----------------------------------------------------------------------------
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no frame in progress, waiting for start
//  ST_LOAD  | frame open, chain paused, waiting for a host word
//  ST_SHIFT | emitting the bits of the held word onto the chain
// ----------------------------------------------------------------------------
module config_loader #(
    parameter int CHAIN_LEN = 32,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              config_en,
    output logic              config_data_in,
    input  logic              config_data_out,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_word,
    output logic              busy,
    output logic              done
);

    localparam int BL_W = $clog2(CHAIN_LEN + 1);
    localparam int BI_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [BL_W-1:0] BITS_FRAME = BL_W'(CHAIN_LEN);
    localparam logic [BL_W-1:0] BITS_ONE   = BL_W'(1);
    localparam logic [BI_W-1:0] IDX_LAST   = BI_W'(WORD_W - 1);
    localparam logic [BI_W-1:0] IDX_ONE    = BI_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [BL_W-1:0]   bits_left;
    logic [BI_W-1:0]   bit_idx;
    logic [WORD_W-1:0] hold;
    logic [WORD_W-1:0] rd_shift;

    logic              handshake;
    logic              word_last;
    logic              frame_last;
    logic [WORD_W-1:0] hold_shifted;
    logic [WORD_W-1:0] rd_next;
    logic [BI_W-1:0]   rd_pad;
    logic [WORD_W-1:0] rd_aligned;

    // config_en is high exactly in SHIFT, so these describe the bit
    // currently on config_data_in.
    assign word_last  = (bit_idx == IDX_LAST);
    assign frame_last = (bits_left == BITS_ONE);
    assign handshake  = word_valid && word_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (handshake) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (frame_last) begin
                    state_nxt = ST_IDLE;
                end else if (word_last && !handshake) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    // During the last bit of a word the next word is requested early so
    // that a waiting host sees no bubble; never on the frame's final bit.
    always_comb begin
        word_ready = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_LOAD: begin
                word_ready = 1'b1;
            end
            ST_SHIFT: begin
                word_ready = word_last && !frame_last;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    // rd_next holds bit_idx+1 freshly captured bits in its LSBs; shifting
    // left by the unused count left-aligns a partial final word and fills
    // the vacated LSBs with zeros.
    always_comb begin
        hold_shifted = hold << 1;
        rd_next      = rd_shift << 1;
        rd_next[0]   = config_data_out;
        rd_pad       = IDX_LAST - bit_idx;
        rd_aligned   = rd_next << rd_pad;
    end

    // ------------------------------------------------------------------
    // Serializer, counters and readback
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bits_left      <= '0;
            bit_idx        <= '0;
            hold           <= '0;
            config_en      <= 1'b0;
            config_data_in <= 1'b0;
            rd_shift       <= '0;
            rd_word        <= '0;
            rd_valid       <= 1'b0;
            done           <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;

            if ((state == ST_IDLE) && start) begin
                bits_left <= BITS_FRAME;
                rd_shift  <= '0;
            end

            // One chain bit is consumed per enabled cycle; its partner bit
            // leaving the chain is captured on the same edge.
            if (config_en) begin
                bits_left <= bits_left - BITS_ONE;
                if (word_last || frame_last) begin
                    rd_word  <= rd_aligned;
                    rd_valid <= 1'b1;
                    rd_shift <= '0;
                end else begin
                    rd_shift <= rd_next;
                end
            end

            if (handshake) begin
                hold           <= word_data;
                bit_idx        <= '0;
                config_en      <= 1'b1;
                config_data_in <= word_data[WORD_W-1];
            end else if (state == ST_SHIFT) begin
                if (frame_last || word_last) begin
                    // Frame end drops any remaining LSBs of the held word.
                    config_en      <= 1'b0;
                    config_data_in <= 1'b0;
                    if (frame_last) begin
                        done <= 1'b1;
                    end
                end else begin
                    hold           <= hold_shifted;
                    bit_idx        <= bit_idx + IDX_ONE;
                    config_data_in <= hold_shifted[WORD_W-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_config_loader.sv
module tb_config_loader;

    logic clk;
    logic nrst;

    // DUT 0: 32-bit chain
    logic        st0, wv0, wr0, cen0, cdi0, cdo0, rdv0, busy0, dn0;
    logic [7:0]  wd0, rw0;
    // DUT 1: 20-bit chain
    logic        st1, wv1, wr1, cen1, cdi1, cdo1, rdv1, busy1, dn1;
    logic [7:0]  wd1, rw1;

    int n_vec;
    int n_err;

    config_loader #(.CHAIN_LEN(32), .WORD_W(8)) u_dut0 (
        .clk(clk), .nrst(nrst), .start(st0), .word_valid(wv0), .word_data(wd0),
        .word_ready(wr0), .config_en(cen0), .config_data_in(cdi0),
        .config_data_out(cdo0), .rd_valid(rdv0), .rd_word(rw0), .busy(busy0),
        .done(dn0)
    );

    config_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut1 (
        .clk(clk), .nrst(nrst), .start(st1), .word_valid(wv1), .word_data(wd1),
        .word_ready(wr1), .config_en(cen1), .config_data_in(cdi1),
        .config_data_out(cdo1), .rd_valid(rdv1), .rd_word(rw1), .busy(busy1),
        .done(dn1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Switchbox chain models: shift on config_en, MSB exits first.
    logic [31:0] sb0, sb0_val;
    logic [19:0] sb1, sb1_val;
    logic        sb0_ld, sb1_ld;

    assign cdo0 = sb0[31];
    assign cdo1 = sb1[19];

    always @(posedge clk) begin
        if (sb0_ld)      sb0 <= sb0_val;
        else if (cen0)   sb0 <= {sb0[30:0], cdi0};
        if (sb1_ld)      sb1 <= sb1_val;
        else if (cen1)   sb1 <= {sb1[18:0], cdi1};
    end

    // Per-cycle observation, sampled mid-cycle.
    int          en_cnt0, hs_cnt0, rdy_cnt0, rd_cnt0, low_cnt0, done_cnt0, done_good0;
    int          en_cnt1, hs_cnt1, rdy_cnt1, rd_cnt1, low_cnt1, done_cnt1, done_good1;
    logic        seen0, seen1, prev_en0, prev_en1;
    logic [31:0] stream0;
    logic [19:0] stream1;
    logic [7:0]  rd_log0 [128];
    logic [7:0]  rd_log1 [128];

    initial begin
        en_cnt0 = 0; hs_cnt0 = 0; rdy_cnt0 = 0; rd_cnt0 = 0; low_cnt0 = 0;
        done_cnt0 = 0; done_good0 = 0; seen0 = 0; prev_en0 = 0; stream0 = '0;
        en_cnt1 = 0; hs_cnt1 = 0; rdy_cnt1 = 0; rd_cnt1 = 0; low_cnt1 = 0;
        done_cnt1 = 0; done_good1 = 0; seen1 = 0; prev_en1 = 0; stream1 = '0;
    end

    always @(negedge clk) begin
        if (cen0) begin
            en_cnt0 <= en_cnt0 + 1;
            stream0 <= {stream0[30:0], cdi0};
        end
        if (wv0 && wr0) hs_cnt0 <= hs_cnt0 + 1;
        if (wr0) rdy_cnt0 <= rdy_cnt0 + 1;
        if (rdv0) begin
            rd_log0[rd_cnt0 % 128] <= rw0;
            rd_cnt0 <= rd_cnt0 + 1;
        end
        if (!busy0) seen0 <= 1'b0;
        else if (cen0) seen0 <= 1'b1;
        if (busy0 && !cen0 && seen0) low_cnt0 <= low_cnt0 + 1;
        if (dn0) begin
            done_cnt0 <= done_cnt0 + 1;
            if (prev_en0 && !cen0 && !busy0) done_good0 <= done_good0 + 1;
        end
        prev_en0 <= cen0;

        if (cen1) begin
            en_cnt1 <= en_cnt1 + 1;
            stream1 <= {stream1[18:0], cdi1};
        end
        if (wv1 && wr1) hs_cnt1 <= hs_cnt1 + 1;
        if (wr1) rdy_cnt1 <= rdy_cnt1 + 1;
        if (rdv1) begin
            rd_log1[rd_cnt1 % 128] <= rw1;
            rd_cnt1 <= rd_cnt1 + 1;
        end
        if (!busy1) seen1 <= 1'b0;
        else if (cen1) seen1 <= 1'b1;
        if (busy1 && !cen1 && seen1) low_cnt1 <= low_cnt1 + 1;
        if (dn1) begin
            done_cnt1 <= done_cnt1 + 1;
            if (prev_en1 && !cen1 && !busy1) done_good1 <= done_good1 + 1;
        end
        prev_en1 <= cen1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic preload(input int sel, input logic [31:0] v);
        if (sel == 0) begin sb0_val = v; sb0_ld = 1'b1; end
        else begin sb1_val = v[19:0]; sb1_ld = 1'b1; end
        @(posedge clk); #1;
        sb0_ld = 1'b0;
        sb1_ld = 1'b0;
    endtask

    task automatic start_frame(input int sel);
        if (sel == 0) st0 = 1'b1; else st1 = 1'b1;
        @(posedge clk); #1;
        st0 = 1'b0;
        st1 = 1'b0;
        n_vec++;
        if (sel == 0 ? !(busy0 && wr0) : !(busy1 && wr1)) begin
            n_err++;
            $display("FAIL start_busy_ready dut%0d: got busy/ready=%b%b required 11", sel,
                     sel == 0 ? busy0 : busy1, sel == 0 ? wr0 : wr1);
        end
    endtask

    task automatic send_word(input int sel, input logic [7:0] w);
        int t;
        logic rdy;
        if (sel == 0) begin wd0 = w; wv0 = 1'b1; end
        else begin wd1 = w; wv1 = 1'b1; end
        t = 0;
        do begin
            @(negedge clk);
            t++;
            rdy = (sel == 0) ? wr0 : wr1;
        end while (!rdy && t < 100);
        n_vec++;
        if (!rdy) begin
            n_err++;
            $display("FAIL word_ready_timeout dut%0d word %h: got ready=0 required 1 within 100 cycles", sel, w);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int sel);
        int t;
        logic b;
        t = 0;
        do begin
            @(negedge clk);
            t++;
            b = (sel == 0) ? busy0 : busy1;
        end while (b && t < 200);
        n_vec++;
        if (b) begin
            n_err++;
            $display("FAIL idle_timeout dut%0d: got busy=1 required 0 within 200 cycles", sel);
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_vec++;
        if ({wr0, cen0, cdi0, rdv0, busy0, dn0, rw0} !== 14'h0) begin
            n_err++;
            $display("FAIL reset_dut0: got %b required all 0", {wr0, cen0, cdi0, rdv0, busy0, dn0, rw0});
        end
        n_vec++;
        if ({wr1, cen1, cdi1, rdv1, busy1, dn1, rw1} !== 14'h0) begin
            n_err++;
            $display("FAIL reset_dut1: got %b required all 0", {wr1, cen1, cdi1, rdv1, busy1, dn1, rw1});
        end
    endtask

    task automatic test_back_to_back();
        int en_b, hs_b, rd_b, lo_b, dn_b, dg_b;
        logic [7:0] exp_rd [4];
        exp_rd = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        preload(0, 32'hCAFEF00D);
        en_b = en_cnt0; hs_b = hs_cnt0; rd_b = rd_cnt0; lo_b = low_cnt0;
        dn_b = done_cnt0; dg_b = done_good0;
        start_frame(0);
        send_word(0, 8'hA5);
        n_vec++;
        if (cen0 !== 1'b1 || cdi0 !== 1'b1) begin
            n_err++;
            $display("FAIL first_bit: got en/data=%b%b required 11", cen0, cdi0);
        end
        send_word(0, 8'h3C);
        send_word(0, 8'hFF);
        send_word(0, 8'h00);
        wv0 = 1'b0;
        wait_idle(0);
        n_vec++;
        if (en_cnt0 - en_b !== 32) begin
            n_err++; $display("FAIL b2b_en_count: got %0d required 32", en_cnt0 - en_b);
        end
        n_vec++;
        if (low_cnt0 - lo_b !== 0) begin
            n_err++; $display("FAIL b2b_contiguous: got %0d gap cycles required 0", low_cnt0 - lo_b);
        end
        n_vec++;
        if (stream0 !== 32'hA53CFF00) begin
            n_err++; $display("FAIL b2b_stream: got %h required a53cff00", stream0);
        end
        n_vec++;
        if (sb0 !== 32'hA53CFF00) begin
            n_err++; $display("FAIL b2b_sb: got %h required a53cff00", sb0);
        end
        n_vec++;
        if (hs_cnt0 - hs_b !== 4) begin
            n_err++; $display("FAIL b2b_handshakes: got %0d required 4", hs_cnt0 - hs_b);
        end
        n_vec++;
        if (done_cnt0 - dn_b !== 1 || done_good0 - dg_b !== 1) begin
            n_err++;
            $display("FAIL b2b_done: got %0d pulses (%0d well-timed) required 1 (1)",
                     done_cnt0 - dn_b, done_good0 - dg_b);
        end
        n_vec++;
        if (rd_cnt0 - rd_b !== 4) begin
            n_err++; $display("FAIL b2b_rd_count: got %0d required 4", rd_cnt0 - rd_b);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rd_log0[(rd_b + i) % 128] !== exp_rd[i]) begin
                n_err++;
                $display("FAIL b2b_rd_word%0d: got %h required %h", i, rd_log0[(rd_b + i) % 128], exp_rd[i]);
            end
        end
    endtask

    task automatic test_stall();
        int en_b, lo_b, dn_b;
        preload(0, 32'h0);
        en_b = en_cnt0; lo_b = low_cnt0; dn_b = done_cnt0;
        start_frame(0);
        send_word(0, 8'hA5);
        send_word(0, 8'h3C);
        wv0 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        send_word(0, 8'hFF);
        send_word(0, 8'h00);
        wv0 = 1'b0;
        wait_idle(0);
        n_vec++;
        if (low_cnt0 - lo_b !== 5) begin
            n_err++; $display("FAIL stall_gap: got %0d low cycles required 5", low_cnt0 - lo_b);
        end
        n_vec++;
        if (en_cnt0 - en_b !== 32) begin
            n_err++; $display("FAIL stall_en_count: got %0d required 32", en_cnt0 - en_b);
        end
        n_vec++;
        if (sb0 !== 32'hA53CFF00) begin
            n_err++; $display("FAIL stall_sb: got %h required a53cff00", sb0);
        end
        n_vec++;
        if (done_cnt0 - dn_b !== 1) begin
            n_err++; $display("FAIL stall_done: got %0d required 1", done_cnt0 - dn_b);
        end
    endtask

    task automatic test_partial();
        int en_b, hs_b, rdy_b, rd_b, dg_b;
        logic [7:0] exp_rd [3];
        exp_rd = '{8'hAB, 8'hCD, 8'hE0};
        preload(1, 32'h000ABCDE);
        en_b = en_cnt1; hs_b = hs_cnt1; rdy_b = rdy_cnt1; rd_b = rd_cnt1; dg_b = done_good1;
        start_frame(1);
        send_word(1, 8'h12);
        send_word(1, 8'h34);
        send_word(1, 8'h5F);
        wd1 = 8'h77;  // host keeps offering a word; none must be taken
        wait_idle(1);
        repeat (3) @(negedge clk);
        wv1 = 1'b0;
        n_vec++;
        if (en_cnt1 - en_b !== 20) begin
            n_err++; $display("FAIL part_en_count: got %0d required 20", en_cnt1 - en_b);
        end
        n_vec++;
        if (stream1 !== 20'h12345) begin
            n_err++; $display("FAIL part_stream: got %h required 12345", stream1);
        end
        n_vec++;
        if (sb1 !== 20'h12345) begin
            n_err++; $display("FAIL part_sb: got %h required 12345", sb1);
        end
        n_vec++;
        if (hs_cnt1 - hs_b !== 3 || rdy_cnt1 - rdy_b !== 3) begin
            n_err++;
            $display("FAIL part_handshakes: got %0d handshakes %0d ready cycles required 3 and 3",
                     hs_cnt1 - hs_b, rdy_cnt1 - rdy_b);
        end
        n_vec++;
        if (done_good1 - dg_b !== 1) begin
            n_err++; $display("FAIL part_done: got %0d required 1", done_good1 - dg_b);
        end
        n_vec++;
        if (rd_cnt1 - rd_b !== 3) begin
            n_err++; $display("FAIL part_rd_count: got %0d required 3", rd_cnt1 - rd_b);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (rd_log1[(rd_b + i) % 128] !== exp_rd[i]) begin
                n_err++;
                $display("FAIL part_rd_word%0d: got %h required %h", i, rd_log1[(rd_b + i) % 128], exp_rd[i]);
            end
        end
    endtask

    task automatic test_readback();
        int rd_b;
        logic [7:0] exp_rd [4];
        exp_rd = '{8'h12, 8'h34, 8'h56, 8'h78};
        preload(0, 32'h12345678);
        rd_b = rd_cnt0;
        start_frame(0);
        send_word(0, 8'hDE);
        send_word(0, 8'hAD);
        send_word(0, 8'hBE);
        send_word(0, 8'hEF);
        wv0 = 1'b0;
        wait_idle(0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rd_log0[(rd_b + i) % 128] !== exp_rd[i]) begin
                n_err++;
                $display("FAIL rb_word%0d: got %h required %h", i, rd_log0[(rd_b + i) % 128], exp_rd[i]);
            end
        end
        n_vec++;
        if (sb0 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL rb_sb: got %h required deadbeef", sb0);
        end
    endtask

    task automatic test_start_ignored();
        int en_b, hs_b, dn_b;
        en_b = en_cnt0; hs_b = hs_cnt0; dn_b = done_cnt0;
        start_frame(0);
        send_word(0, 8'h01);
        send_word(0, 8'h80);
        wv0 = 1'b0;
        @(posedge clk); #1;
        st0 = 1'b1;
        @(posedge clk); #1;
        st0 = 1'b0;
        send_word(0, 8'h55);
        send_word(0, 8'hAA);
        wv0 = 1'b0;
        wait_idle(0);
        n_vec++;
        if (en_cnt0 - en_b !== 32) begin
            n_err++; $display("FAIL restart_en_count: got %0d required 32", en_cnt0 - en_b);
        end
        n_vec++;
        if (hs_cnt0 - hs_b !== 4) begin
            n_err++; $display("FAIL restart_handshakes: got %0d required 4", hs_cnt0 - hs_b);
        end
        n_vec++;
        if (sb0 !== 32'h018055AA) begin
            n_err++; $display("FAIL restart_sb: got %h required 018055aa", sb0);
        end
        n_vec++;
        if (done_cnt0 - dn_b !== 1) begin
            n_err++; $display("FAIL restart_done: got %0d required 1", done_cnt0 - dn_b);
        end
    endtask

    task automatic test_nrst_midframe();
        preload(0, 32'hFFFFFFFF);
        start_frame(0);
        send_word(0, 8'hA5);
        send_word(0, 8'h3C);
        wv0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (rw0 !== 8'hFF || cen0 !== 1'b1) begin
            n_err++; $display("FAIL pre_reset: got rd_word=%h en=%b required ff 1", rw0, cen0);
        end
        nrst = 1'b0;
        #1;
        n_vec++;
        if ({wr0, cen0, cdi0, rdv0, busy0, dn0, rw0} !== 14'h0) begin
            n_err++;
            $display("FAIL midframe_reset: got %b required all 0", {wr0, cen0, cdi0, rdv0, busy0, dn0, rw0});
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (busy0 !== 1'b0) begin
            n_err++; $display("FAIL post_reset_idle: got busy=%b required 0", busy0);
        end
        start_frame(0);
        send_word(0, 8'hA5);
        send_word(0, 8'h3C);
        send_word(0, 8'hFF);
        send_word(0, 8'h00);
        wv0 = 1'b0;
        wait_idle(0);
        n_vec++;
        if (sb0 !== 32'hA53CFF00) begin
            n_err++; $display("FAIL post_reset_sb: got %h required a53cff00", sb0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        nrst = 1'b0;
        st0 = 1'b0; wv0 = 1'b0; wd0 = '0;
        st1 = 1'b0; wv1 = 1'b0; wd1 = '0;
        sb0_ld = 1'b0; sb1_ld = 1'b0; sb0_val = '0; sb1_val = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        nrst = 1'b1;
        @(posedge clk); #1;
        test_back_to_back();
        test_stall();
        test_partial();
        test_readback();
        test_start_ignored();
        test_nrst_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
